// File: rtl/datamemory_lsu.sv
// datamemory_lsu
//   Data memory with a load/store unit for the RV32I datapath. It handles
//   LB/LH/LW/LBU/LHU/SB/SH/SW with per-byte lane enables and sign or zero
//   extension. Requests use a valid/ready handshake. Each request gets one
//   response pulse LATENCY cycles after the edge that accepted it.
//
//   Parameters
//     DM_ADDRESS  byte-address width; the array has 2**(DM_ADDRESS-2) words
//     DATA_W      data width; must be 32
//     LATENCY     cycles from the accept edge to the access edge (>=1)
//
//   Ports
//     clk         rising-edge clock
//     reset       asynchronous, active-high
//     req_valid   request present; held stable until accepted
//     req_ready   high when a request can be accepted (FSM idle)
//     req_we      1 = store, 0 = load
//     req_funct3  instr[14:12]
//     req_addr    byte address
//     req_wdata   store data; the low byte/half is used for SB/SH
//     resp_valid  one-cycle response pulse
//     resp_rdata  extended load data; 0 for stores and errors
//     resp_err    access rejected; qualified by resp_valid
//
//   Build option
//     DM_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses
//                          complete with resp_err=1. When undefined, the
//                          offset is forced to alignment.
module datamemory_lsu #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err
);

    localparam int DEPTH = 2 ** (DM_ADDRESS - 2);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic                    accept, fire;

    logic                    q_we;
    logic [2:0]              q_f3;
    logic [DM_ADDRESS-1:0]   q_addr;
    logic [DATA_W-1:0]       q_wdata;

    logic [DATA_W-1:0]       mem [DEPTH];

    logic [DM_ADDRESS-3:0]   widx;
    logic [1:0]              off, eff_off;
    logic                    illegal, err;
    logic [DATA_W-1:0]       word, shifted, load_data, wlane;
    logic [3:0]              be;
    logic                    wr_en;

    // Next-state and handshake logic
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        fire      = 1'b0;
        req_ready = (state == IDLE);
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    fire      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the request on accept and count down while busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            q_we    <= 1'b0;
            q_f3    <= '0;
            q_addr  <= '0;
            q_wdata <= '0;
        end else if (accept) begin
            cnt     <= CNT_W'(LATENCY - 1);
            q_we    <= req_we;
            q_f3    <= req_funct3;
            q_addr  <= req_addr;
            q_wdata <= req_wdata;
        end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Decode the latched access: lane offset, errors, load extension, write lanes
    always_comb begin
        widx    = q_addr[DM_ADDRESS-1:2];
        off     = q_addr[1:0];
        illegal = (q_f3 == 3'b011) || (q_f3 == 3'b110) || (q_f3 == 3'b111);
`ifdef DM_MISALIGN_TRAP_EN
        eff_off = off;
        err     = illegal
                || (q_f3[1:0] == 2'b01 && off[0])
                || (q_f3[1:0] == 2'b10 && off != 2'b00);
`else
        // Misaligned offsets are forced to the natural alignment
        case (q_f3[1:0])
            2'b01:   eff_off = {off[1], 1'b0};
            2'b10:   eff_off = 2'b00;
            default: eff_off = off;
        endcase
        err     = illegal;
`endif
        word    = mem[widx];
        shifted = word >> {eff_off, 3'b000};

        case (q_f3)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_data = shifted;
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = '0;
        endcase
        if (q_we || err) begin
            load_data = '0;
        end

        // Replicate store data across lanes so the byte enable alone selects
        case (q_f3[1:0])
            2'b00: begin
                be    = 4'b0001 << eff_off;
                wlane = {4{q_wdata[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << eff_off;
                wlane = {2{q_wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = q_wdata;
            end
        endcase
        wr_en = fire && q_we && !err;
    end

    // Memory array has no reset and keeps its contents across reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx][i*8 +: 8] <= wlane[i*8 +: 8];
                end
            end
        end
    end

    // Response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= fire;
            if (fire) begin
                resp_rdata <= load_data;
                resp_err   <= err;
            end
        end
    end

endmodule

// File: tb/tb_datamemory_lsu.sv
module tb_datamemory_lsu;

    localparam int LAT = 3;
`ifdef DM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [8:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    datamemory_lsu #(.DM_ADDRESS(9), .DATA_W(32), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One full transaction; lat = edges from accept to response (0 on timeout)
    task automatic do_access(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rdata,
                             output logic err, output int lat);
        int g;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat   = 0;
        rdata = 32'hxxxx_xxxx;
        err   = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) begin
                lat   = i;
                rdata = resp_rdata;
                err   = resp_err;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          acc;
        int          pulses;
        int          t0, t1;
        int          stray;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", {31'd0, resp_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors, applied in order (memory state carries forward)
        vq.push_back('{1'b1, F_W,    9'h020, 32'h12345678, 32'h00000000, 1'b0});
        vq.push_back('{1'b0, F_W,    9'h020, 32'h0,        32'h12345678, 1'b0});
        vq.push_back('{1'b1, F_W,    9'h020, 32'h00000000, 32'h00000000, 1'b0});
        vq.push_back('{1'b1, F_B,    9'h021, 32'hAAAAAA80, 32'h00000000, 1'b0});
        vq.push_back('{1'b0, F_B,    9'h021, 32'h0,        32'hFFFFFF80, 1'b0});
        vq.push_back('{1'b0, F_BU,   9'h021, 32'h0,        32'h00000080, 1'b0});
        vq.push_back('{1'b0, F_W,    9'h020, 32'h0,        32'h00008000, 1'b0});
        vq.push_back('{1'b1, F_H,    9'h022, 32'h55558001, 32'h00000000, 1'b0});
        vq.push_back('{1'b0, F_H,    9'h022, 32'h0,        32'hFFFF8001, 1'b0});
        vq.push_back('{1'b0, F_HU,   9'h022, 32'h0,        32'h00008001, 1'b0});
        vq.push_back('{1'b0, F_W,    9'h020, 32'h0,        32'h80018000, 1'b0});
        vq.push_back('{1'b0, 3'b111, 9'h020, 32'h0,        32'h00000000, 1'b1});
        vq.push_back('{1'b1, 3'b011, 9'h020, 32'hFFFFFFFF, 32'h00000000, 1'b1});
        vq.push_back('{1'b0, F_W,    9'h020, 32'h0,        32'h80018000, 1'b0});
        vq.push_back('{1'b0, F_W,    9'h023, 32'h0,        TRAP ? 32'h0 : 32'h80018000, TRAP});
        vq.push_back('{1'b0, F_B,    9'h023, 32'h0,        32'hFFFFFF80, 1'b0});
        vq.push_back('{1'b0, F_B,    9'h022, 32'h0,        32'h00000001, 1'b0});
        vq.push_back('{1'b0, F_H,    9'h020, 32'h0,        32'hFFFF8000, 1'b0});
        vq.push_back('{1'b1, F_W,    9'h1FC, 32'h00000000, 32'h00000000, 1'b0});
        vq.push_back('{1'b1, F_B,    9'h1FF, 32'h1234567F, 32'h00000000, 1'b0});
        vq.push_back('{1'b0, F_B,    9'h1FF, 32'h0,        32'h0000007F, 1'b0});
        vq.push_back('{1'b0, F_W,    9'h1FC, 32'h0,        32'h7F000000, 1'b0});
        vq.push_back('{1'b1, F_H,    9'h1FD, 32'h0000BEEF, 32'h00000000, TRAP});
        vq.push_back('{1'b0, F_W,    9'h1FC, 32'h0,        TRAP ? 32'h7F000000 : 32'h7F00BEEF, 1'b0});
        vq.push_back('{1'b0, 3'b110, 9'h1FC, 32'h0,        32'h00000000, 1'b1});

        foreach (vq[k]) begin
            do_access(vq[k].we, vq[k].f3, vq[k].addr, vq[k].wdata, rd, er, lat);
            check($sformatf("vec%0d_lat", k), lat, LAT);
            check($sformatf("vec%0d_rdata", k), rd, vq[k].exp_rdata);
            check($sformatf("vec%0d_err", k), {31'd0, er}, {31'd0, vq[k].exp_err});
        end

        // Reset while BUSY aborts the store
        do_access(1'b1, F_W, 9'h010, 32'h11111111, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F_W;
        req_addr = 9'h010; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("midrst_busy", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (resp_valid) stray++;
        end
        check("midrst_no_resp", stray, 0);
        do_access(1'b0, F_W, 9'h010, 32'h0, rd, er, lat);
        check("midrst_old_data", rd, 32'h11111111);

        // Held req_valid during BUSY, back-to-back accept on the response cycle
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F_W;
        req_addr = 9'h020; req_wdata = 32'h0;
        acc = 0; pulses = 0; t0 = -1; t1 = -1;
        for (int k = 0; k < 14; k++) begin
            if (k > 0) @(negedge clk);
            if (req_valid && req_ready) acc++;
            @(posedge clk);
            #1;
            if (k == 4) req_valid = 1'b0;
            if (resp_valid) begin
                pulses++;
                if (t0 < 0) t0 = k; else if (t1 < 0) t1 = k;
                check($sformatf("b2b_rdata%0d", pulses), resp_rdata, 32'h80018000);
            end
        end
        check("b2b_accepts", acc, 2);
        check("b2b_pulses", pulses, 2);
        check("b2b_first", t0, LAT);
        check("b2b_spacing", t1 - t0, LAT + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
